// File: rtl/mag2comp_serial_pkg.sv
// Shared definitions for the serial sign/magnitude to two's-complement converter.
package mag2comp_serial_pkg;

    localparam logic [1:0] IDLE_CODE = 2'd0;
    localparam logic [1:0] BUSY_CODE = 2'd1;
    localparam logic [1:0] DONE_CODE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_CODE,
        BUSY = BUSY_CODE,
        DONE = DONE_CODE
    } state_t;

    // Bits needed to count 0 .. value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mag2comp_serial_if.sv
// Operand and result handshake bundle of the serial re-signing block.
interface mag2comp_serial_if #(
    parameter int NUMBER_OF_BITS = 12
);

    logic                      in_valid;
    logic                      in_ready;
    logic                      sign;
    logic [NUMBER_OF_BITS-1:0] mag;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUMBER_OF_BITS-1:0] comp;
    logic                      ovf;

    modport master (
        output in_valid,
        output sign,
        output mag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  comp,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  sign,
        input  mag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output comp,
        output ovf
    );

endinterface

// File: rtl/mag2comp_serial_negate_cell.sv
// One-bit serial negation: copy bits up to and including the first one, invert the rest.
module serial_negate_cell (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic sign,
    input  logic m,
    output logic out_bit
);

    logic seen_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_one <= 1'b0;
        end else if (clear) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | m;
        end
    end

    assign out_bit = (sign & seen_one) ? ~m : m;

endmodule

// File: rtl/mag2comp_serial.sv
// Re-signs a sign + magnitude operand into N-bit two's complement, one bit per clock, LSB first.
module mag2comp_serial
    import mag2comp_serial_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    mag2comp_serial_if.slave bus
);

    localparam int N     = NUMBER_OF_BITS;
    localparam int CNT_W = clog2(N);

    localparam logic [CNT_W-1:0] LAST_STEP    = CNT_W'(N - 1);
    localparam logic [N-1:0]     MOST_NEG_MAG = {1'b1, {(N-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             sign_r;
    logic [N-1:0]     shift_reg;
    logic [N-2:0]     result;
    logic [N-1:0]     result_next;
    logic             ovf_next;
    logic             out_bit;
    logic             accept;
    logic             step;

    assign bus.in_ready = (state == IDLE) & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;
    assign step         = (state == BUSY);

    // result holds the upper N-1 bits collected so far; the newest bit enters at the MSB.
    assign result_next = {out_bit, result};

    serial_negate_cell u_negate (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (step),
        .sign    (sign_r),
        .m       (shift_reg[0]),
        .out_bit (out_bit)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            sign_r    <= bus.sign;
            shift_reg <= bus.mag;
            ovf_next  <= bus.sign ? (bus.mag > MOST_NEG_MAG) : bus.mag[N-1];
        end else if (step) begin
            shift_reg <= shift_reg >> 1;
            result    <= result_next[N-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.comp      <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bit_cnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bit_cnt == LAST_STEP) begin
                        // Clear rather than increment so the counter never wraps.
                        bit_cnt       <= '0;
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.comp      <= result_next;
                        bus.ovf       <= ovf_next;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    valid_matches_done: assert property (
        @(posedge clk) disable iff (rst) bus.out_valid == (state == DONE)
    );

endmodule

// File: doc/mag2comp_serial.md
Name: mag2comp_serial

Overview:
- Converts a sign + unsigned-magnitude operand back to N-bit two's complement, one bit per clock, LSB first.
- Used on the Booth multiplier output path, where operands were reduced to magnitude for the array and the product must be re-signed.
- The serial copy-until-first-one / invert-after algorithm keeps area small.
- Valid/ready handshake on both input and output.

Parameters:
- NUMBER_OF_BITS, 12, width of magnitude input and two's-complement output (>= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sign/mag valid
- in_ready  output  1  block can accept an operand (IDLE only)
- sign  input  1  1 = negative
- mag  input  NUMBER_OF_BITS  unsigned magnitude
- out_valid  output  1  comp/ovf valid, held until accepted
- out_ready  input  1  downstream accepts result
- comp  output  NUMBER_OF_BITS  two's-complement result
- ovf  output  1  value not representable; comp holds wrapped result

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, out_valid=0, comp=0, ovf=0, bit counter=0, seen_one=0. in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Reset mid-operation (BUSY or DONE) aborts the conversion. Nothing is output for the aborted operand.
- FSM states:
  - IDLE -> BUSY on in_valid & in_ready.
  - BUSY -> DONE after NUMBER_OF_BITS bit-steps.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE) & ~rst.
- Accept edge:
  - Capture sign and mag into internal registers.
  - Clear counter and seen_one.
  - Register ovf_next = sign ? (mag > 2^(N-1)) : mag[N-1].
  - Input changes after acceptance are ignored.
- BUSY, each edge:
  - Take m = shift_reg[0].
  - out_bit = (sign & seen_one) ? ~m : m.
  - seen_one <= seen_one | m.
  - Shift the magnitude register right by 1.
  - Shift out_bit into the result register at MSB, shifting right.
  - Counter += 1. On the edge where counter == N-1, go to DONE.
- Latency: out_valid rises exactly N clock edges after the acceptance edge.
- DONE:
  - out_valid=1; comp and ovf are stable until out_ready is sampled high.
  - in_valid is ignored.
  - Handshake edge -> IDLE. The next operand cannot be accepted in the same cycle.
  - Throughput is 1 result per N+2 cycles with out_ready tied high.
- Result arithmetic:
  - comp = sign ? (2^N - mag) mod 2^N : mag.
  - Negative zero (sign=1, mag=0) yields comp=0, ovf=0.
  - sign=1, mag=2^(N-1) yields the most negative value, ovf=0.
- comp keeps its last value while in IDLE/BUSY, but is only meaningful when out_valid=1.
- Counter width is clog2(N). The counter must not wrap inside BUSY.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - clog2 helper for counter width
- One natural sub-module, serial_negate_cell:
  - Contains the seen_one flop and the out_bit logic.
  - Inputs: clk, rst, clear, en, sign, m. Output: out_bit.

Test Plan:
- N=12, sign=0, mag=0x123 -> comp=0x123, ovf=0. out_valid rises 12 edges after accept; in_ready=0 from accept until the DONE handshake.
- sign=1, mag=0x123 -> comp=0xEDD, ovf=0. sign=1, mag=0x001 -> comp=0xFFF.
- Boundaries:
  - sign=1, mag=0x800 -> comp=0x800, ovf=0
  - sign=0, mag=0x800 -> comp=0x800, ovf=1
  - sign=1, mag=0x801 -> comp=0x7FF, ovf=1
  - sign=1, mag=0x000 -> comp=0x000, ovf=0
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and sign/mag. comp/ovf/out_valid must stay stable and in_ready must stay 0. When out_ready=1, out_valid drops next cycle and in_ready=1.
- Reset while 6 bits have been processed -> next cycle out_valid=0, state IDLE. A following operand (sign=1, mag=0x00F) converts correctly to comp=0xFF1.
- Exhaustive round trip: for every 12-bit x, drive sign=x[11], mag=(x[11] ? -x : x) mod 4096. Require comp==x and ovf=0 for all 4096 values.
